// File: rtl/pipeline_sequencer_pkg.sv
// rtl/pipeline_sequencer_pkg.sv - shared sequencer types and constants (package core_pkg)
package core_pkg;

    // Width of the per-state wait counter; bounds every latency parameter to 1..15.
    localparam int SEQ_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        UART   = 3'd5,
        WB     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - decode flags, UART handshakes and stage strobes of the sequencer
interface pipeline_sequencer_if;

    logic run;
    logic MemRead;
    logic MemWrite;
    logic UARTtoReg;
    logic RegtoUART;
    logic RegWrite;
    logic uart_rx_valid;
    logic uart_tx_ready;

    logic fetch_en;
    logic inst_enable;
    logic exec_en;
    logic mem_en;
    logic uart_rd_req;
    logic uart_wr_req;
    logic reg_we;
    logic pc_we;
    logic retire;
    logic busy;

    // Core/datapath side: drives run, decode flags and UART status, observes strobes.
    modport master (
        output run, MemRead, MemWrite, UARTtoReg, RegtoUART, RegWrite,
        output uart_rx_valid, uart_tx_ready,
        input  fetch_en, inst_enable, exec_en, mem_en, uart_rd_req, uart_wr_req,
        input  reg_we, pc_we, retire, busy
    );

    // Sequencer side.
    modport slave (
        input  run, MemRead, MemWrite, UARTtoReg, RegtoUART, RegWrite,
        input  uart_rx_valid, uart_tx_ready,
        output fetch_en, inst_enable, exec_en, mem_en, uart_rd_req, uart_wr_req,
        output reg_we, pc_we, retire, busy
    );

endinterface

// File: rtl/pipeline_sequencer_perf.sv
// rtl/pipeline_sequencer_perf.sv - busy-cycle and retire counters (built with PIPELINE_SEQUENCER_PERF_EN)
`ifdef PIPELINE_SEQUENCER_PERF_EN
module perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        busy_i,
    input  logic        retire_i,
    output logic [31:0] cycle_count_o,
    output logic [31:0] retire_count_o
);

    logic [31:0] cycle_q;
    logic [31:0] retire_q;

    // Count busy cycles and retired instructions; both wrap modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            if (busy_i) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (retire_i) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    assign cycle_count_o  = cycle_q;
    assign retire_count_o = retire_q;

endmodule
`endif

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - multi-cycle fetch/decode/exec/mem-uart/wb control FSM; PIPELINE_SEQUENCER_PERF_EN adds perf counters
module pipeline_sequencer
    import core_pkg::*;
#(
    parameter int IMEM_LATENCY  = 1,
    parameter int DECODE_CYCLES = 3,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                 CLK,
    input  logic                 reset,
    pipeline_sequencer_if.slave  bus
`ifdef PIPELINE_SEQUENCER_PERF_EN
    ,
    output logic [31:0]          cycle_count,
    output logic [31:0]          retire_count
`endif
);

    // The wait counter is 4 bits, so every latency must fit in 1..15.
    if (IMEM_LATENCY < 1 || IMEM_LATENCY > 15) begin : g_bad_imem
        $error("IMEM_LATENCY must be in 1..15");
    end
    if (DECODE_CYCLES < 1 || DECODE_CYCLES > 15) begin : g_bad_decode
        $error("DECODE_CYCLES must be in 1..15");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_mem
        $error("MEM_LATENCY must be in 1..15");
    end

    localparam logic [SEQ_CNT_W-1:0] IMEM_LAST = SEQ_CNT_W'(IMEM_LATENCY - 1);
    localparam logic [SEQ_CNT_W-1:0] DEC_LAST  = SEQ_CNT_W'(DECODE_CYCLES - 1);
    localparam logic [SEQ_CNT_W-1:0] MEM_LAST  = SEQ_CNT_W'(MEM_LATENCY - 1);
    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    seq_state_t           state_q, state_d;
    logic [SEQ_CNT_W-1:0] cnt_q, cnt_d;
    logic                 dir_q, dir_d;
    logic                 rw_q, rw_d;

    logic fetch_en_q, inst_enable_q, exec_en_q, mem_en_q;
    logic uart_rd_req_q, uart_wr_req_q, reg_we_q, pc_we_q, retire_q, busy_q;

    // Next-state selection; the counter only advances in the fixed-latency states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rw_d    = rw_q;
        case (state_q)
            IDLE: begin
                if (bus.run) state_d = FETCH;
            end
            FETCH: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == IMEM_LAST) state_d = DECODE;
            end
            DECODE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == DEC_LAST) state_d = EXEC;
            end
            EXEC: begin
                rw_d = bus.RegWrite;
                if (bus.MemRead || bus.MemWrite) begin
                    state_d = MEM;
                end else if (bus.UARTtoReg) begin
                    state_d = UART;
                    dir_d   = DIR_RD;
                end else if (bus.RegtoUART) begin
                    state_d = UART;
                    dir_d   = DIR_WR;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == MEM_LAST) state_d = WB;
            end
            UART: begin
                if ((dir_q == DIR_RD) ? bus.uart_rx_valid : bus.uart_tx_ready) state_d = WB;
            end
            WB: begin
                state_d = bus.run ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // State register plus Moore strobes registered from the upcoming state so they align with it.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dir_q         <= DIR_RD;
            rw_q          <= 1'b0;
            fetch_en_q    <= 1'b0;
            inst_enable_q <= 1'b0;
            exec_en_q     <= 1'b0;
            mem_en_q      <= 1'b0;
            uart_rd_req_q <= 1'b0;
            uart_wr_req_q <= 1'b0;
            reg_we_q      <= 1'b0;
            pc_we_q       <= 1'b0;
            retire_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            rw_q          <= rw_d;
            fetch_en_q    <= (state_d == FETCH);
            inst_enable_q <= (state_d == DECODE) && (state_q != DECODE);
            exec_en_q     <= (state_d == EXEC);
            mem_en_q      <= (state_d == MEM);
            uart_rd_req_q <= (state_d == UART) && (dir_d == DIR_RD);
            uart_wr_req_q <= (state_d == UART) && (dir_d == DIR_WR);
            reg_we_q      <= (state_d == WB) && rw_d;
            pc_we_q       <= (state_d == WB);
            retire_q      <= (state_d == WB);
            busy_q        <= (state_d != IDLE);
        end
    end

    assign bus.fetch_en    = fetch_en_q;
    assign bus.inst_enable = inst_enable_q;
    assign bus.exec_en     = exec_en_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.uart_rd_req = uart_rd_req_q;
    assign bus.uart_wr_req = uart_wr_req_q;
    assign bus.reg_we      = reg_we_q;
    assign bus.pc_we       = pc_we_q;
    assign bus.retire      = retire_q;
    assign bus.busy        = busy_q;

`ifdef PIPELINE_SEQUENCER_PERF_EN
    perf_counters u_perf (
        .clk            (CLK),
        .rst_n          (reset),
        .busy_i         (busy_q),
        .retire_i       (retire_q),
        .cycle_count_o  (cycle_count),
        .retire_count_o (retire_count)
    );
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - randomized self-checking bench for pipeline_sequencer
module tb_pipeline_sequencer;

    localparam int IMEM = 1;
    localparam int DEC  = 3;
    localparam int MEML = 2;

    localparam logic [9:0] V_FETCH = 10'h001;
    localparam logic [9:0] V_INST  = 10'h002;
    localparam logic [9:0] V_EXEC  = 10'h004;
    localparam logic [9:0] V_MEM   = 10'h008;
    localparam logic [9:0] V_RD    = 10'h010;
    localparam logic [9:0] V_WR    = 10'h020;
    localparam logic [9:0] V_REGWE = 10'h040;
    localparam logic [9:0] V_PC    = 10'h080;
    localparam logic [9:0] V_RET   = 10'h100;
    localparam logic [9:0] V_BUSY  = 10'h200;

    logic CLK;
    logic reset;
    pipeline_sequencer_if bus();
`ifdef PIPELINE_SEQUENCER_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] retire_count;
`endif

    pipeline_sequencer #(
        .IMEM_LATENCY  (IMEM),
        .DECODE_CYCLES (DEC),
        .MEM_LATENCY   (MEML)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
`ifdef PIPELINE_SEQUENCER_PERF_EN
        ,
        .cycle_count  (cycle_count),
        .retire_count (retire_count)
`endif
    );

    logic [9:0] dut_vec;
    assign dut_vec = {bus.busy, bus.retire, bus.pc_we, bus.reg_we, bus.uart_wr_req,
                      bus.uart_rd_req, bus.mem_en, bus.exec_en, bus.inst_enable, bus.fetch_en};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: each instruction is a list of expected output words per cycle.
    logic [9:0]  plan[$];
    logic [9:0]  cur   = '0;
    int          waiting = 0;
    logic        rw_m  = 1'b0;
    logic [31:0] mcyc  = '0;
    logic [31:0] mret  = '0;

    task automatic push_prefix();
        for (int i = 0; i < IMEM; i++) plan.push_back(V_BUSY | V_FETCH);
        for (int i = 0; i < DEC; i++) plan.push_back((i == 0) ? (V_BUSY | V_INST) : V_BUSY);
        plan.push_back(V_BUSY | V_EXEC);
    endtask

    task automatic push_wb();
        plan.push_back(V_BUSY | V_PC | V_RET | (rw_m ? V_REGWE : 10'h000));
    endtask

    initial forever begin
        @(posedge CLK or negedge reset);
        if (!reset) begin
            plan.delete();
            cur = '0; waiting = 0; rw_m = 1'b0; mcyc = '0; mret = '0;
        end else begin
            if (cur[9]) mcyc = mcyc + 32'd1;
            if (cur[8]) mret = mret + 32'd1;
            if (cur[2]) begin
                rw_m = bus.RegWrite;
                if (bus.MemRead || bus.MemWrite) begin
                    repeat (MEML) plan.push_back(V_BUSY | V_MEM);
                    push_wb();
                end else if (bus.UARTtoReg) waiting = 1;
                else if (bus.RegtoUART) waiting = 2;
                else push_wb();
            end else if (waiting == 1 && plan.size() == 0 && bus.uart_rx_valid) begin
                waiting = 0; push_wb();
            end else if (waiting == 2 && plan.size() == 0 && bus.uart_tx_ready) begin
                waiting = 0; push_wb();
            end else if ((cur[8] || !cur[9]) && bus.run) begin
                push_prefix();
            end
            if (plan.size() > 0) cur = plan.pop_front();
            else if (waiting == 1) cur = V_BUSY | V_RD;
            else if (waiting == 2) cur = V_BUSY | V_WR;
            else cur = '0;
        end
    end

    // Every cycle, compare the DUT against the model away from the active edge.
    initial forever begin
        @(negedge CLK);
        check("outputs_vs_model", 32'(dut_vec), 32'(cur));
`ifdef PIPELINE_SEQUENCER_PERF_EN
        check("cycle_count_vs_model", cycle_count, mcyc);
        check("retire_count_vs_model", retire_count, mret);
`endif
    end

    int rd_cnt, mem_cnt;
    logic wr_seen, ret_seen;

    initial begin
        reset = 1'b1;
        bus.run = 0; bus.MemRead = 0; bus.MemWrite = 0; bus.UARTtoReg = 0;
        bus.RegtoUART = 0; bus.RegWrite = 0; bus.uart_rx_valid = 0; bus.uart_tx_ready = 0;
        #1 reset = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_state", 32'(dut_vec), 32'd0);
        bus.run = 1; bus.RegWrite = 1; reset = 1'b1;
        @(negedge CLK);
        check("first_fetch", 32'(bus.fetch_en), 32'd1);
        #2 reset = 1'b0;
        #1 check("reset_mid_fetch", 32'(dut_vec), 32'd0);
        @(negedge CLK);
        reset = 1'b1;
        rd_cnt = 0; mem_cnt = 0; wr_seen = 1'b0;
        for (int k = 1; k <= 54; k++) begin
            @(negedge CLK);
            if (bus.uart_rd_req) rd_cnt++;
            if (k >= 31 && k <= 38 && bus.mem_en) mem_cnt++;
            if (k >= 31 && k <= 38 && bus.uart_wr_req) wr_seen = 1'b1;
            case (k)
                1:  check("alu_fetch_c1", 32'(bus.fetch_en), 32'd1);
                2:  check("alu_inst_en_c2", 32'(bus.inst_enable), 32'd1);
                3:  check("alu_inst_en_c3", 32'(bus.inst_enable), 32'd0);
                5:  check("alu_exec_c5", 32'(bus.exec_en), 32'd1);
                6:  check("alu_wb_c6", 32'({bus.reg_we, bus.pc_we, bus.retire}), 32'd7);
                7:  begin
                        check("alu_refetch_c7", 32'(bus.fetch_en), 32'd1);
                        bus.MemRead = 1;
                    end
                11: check("load_exec_c11", 32'(bus.exec_en), 32'd1);
                12: check("load_mem_c12", 32'(bus.mem_en), 32'd1);
                13: check("load_mem_c13", 32'(bus.mem_en), 32'd1);
                14: begin
                        check("load_wb_c14", 32'({bus.mem_en, bus.retire}), 32'd1);
                        bus.MemRead = 0; bus.UARTtoReg = 1;
                    end
                29: bus.uart_rx_valid = 1;
                30: begin
                        check("uart_rd_cycles", 32'(rd_cnt), 32'd10);
                        check("uart_rd_wb", 32'({bus.uart_rd_req, bus.retire}), 32'd1);
                        bus.uart_rx_valid = 0; bus.UARTtoReg = 0;
                        bus.RegtoUART = 1; bus.MemWrite = 1;
                    end
                38: begin
                        check("both_flags_no_wr_req", 32'(wr_seen), 32'd0);
                        check("both_flags_mem_cycles", 32'(mem_cnt), 32'd2);
                        check("both_flags_retire", 32'(bus.retire), 32'd1);
                        bus.RegtoUART = 0; bus.MemWrite = 0;
                    end
                41: bus.run = 0;
                44: check("run_drop_retire", 32'(bus.retire), 32'd1);
                45: check("run_drop_idle", 32'(bus.busy), 32'd0);
                46: begin
                        check("run_drop_still_idle", 32'(bus.busy), 32'd0);
                        bus.run = 1; bus.UARTtoReg = 1;
                    end
                54: begin
                        check("uart_wait_req", 32'(bus.uart_rd_req), 32'd1);
                        #2 reset = 1'b0;
                        #1 check("reset_in_uart", 32'(dut_vec), 32'd0);
                    end
                default: ;
            endcase
        end
        bus.run = 0; bus.UARTtoReg = 0;
        ret_seen = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (bus.retire) ret_seen = 1'b1;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (bus.retire) ret_seen = 1'b1;
        end
        check("no_retire_after_reset", 32'(ret_seen), 32'd0);
        check("idle_after_reset", 32'(bus.busy), 32'd0);

        // Random phase: the model comparison runs every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            bus.run           = ($urandom_range(0, 9) != 0);
            bus.MemRead       = ($urandom_range(0, 3) == 0);
            bus.MemWrite      = ($urandom_range(0, 3) == 0);
            bus.UARTtoReg     = ($urandom_range(0, 3) == 0);
            bus.RegtoUART     = ($urandom_range(0, 3) == 0);
            bus.RegWrite      = ($urandom_range(0, 1) == 0);
            bus.uart_rx_valid = ($urandom_range(0, 9) < 3);
            bus.uart_tx_ready = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b0;
                @(negedge CLK);
                #2 reset = 1'b1;
            end
        end

`ifdef PIPELINE_SEQUENCER_PERF_EN
        @(negedge CLK);
        #2 reset = 1'b0;
        bus.run = 1; bus.MemRead = 0; bus.MemWrite = 0; bus.UARTtoReg = 0; bus.RegtoUART = 0;
        @(negedge CLK);
        reset = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge CLK);
            if (k == 18) begin
                check("perf_third_retire", 32'(bus.retire), 32'd1);
                bus.run = 0;
            end
        end
        repeat (3) @(negedge CLK);
        check("perf_retire_count", retire_count, 32'd3);
        check("perf_cycle_count", cycle_count, 32'd18);
`endif

        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Multi-cycle control FSM that steps the CPU core through fetch, decode, execute, memory/UART and writeback, one instruction at a time.
- Generates the per-stage enable strobes, including the `inst_enable` pulse consumed by the decode stage.
- Holds the machine on memory latency and UART handshakes.
- Sits beside the datapath in the core top level, driven by the decode-stage control outputs.

Parameters:
- IMEM_LATENCY, 1, cycles from `fetch_en` until the instruction word is valid at decode input (1..15).
- DECODE_CYCLES, 3, cycles the decode stage needs from `inst_enable` until its control outputs are valid (1..15).
- MEM_LATENCY, 2, cycles `mem_en` is held for a data-memory access (1..15).

Ports:
- CLK  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- run  input  1  level; 1 = keep issuing instructions
- MemRead  input  1  from decode
- MemWrite  input  1  from decode
- UARTtoReg  input  1  from decode
- RegtoUART  input  1  from decode
- RegWrite  input  1  from decode
- uart_rx_valid  input  1  UART receive byte available
- uart_tx_ready  input  1  UART transmitter can accept a byte
- fetch_en  output  1  instruction memory read strobe
- inst_enable  output  1  decode start pulse
- exec_en  output  1  ALU/branch evaluation strobe
- mem_en  output  1  data-memory access enable
- uart_rd_req  output  1  UART read request
- uart_wr_req  output  1  UART write request
- reg_we  output  1  register-file write enable
- pc_we  output  1  PC update strobe
- retire  output  1  instruction-complete pulse
- busy  output  1  state != IDLE

Behaviour:
- **Reset.** `reset`=0 asynchronously forces state IDLE, the wait counter to 0 and every output to 0.
- **Output encoding.** All outputs are registered Moore outputs decoded from the state; none is combinational from inputs.
- **States.** IDLE, FETCH, DECODE, EXEC, MEM, UART, WB. A 4-bit wait counter `cnt` is cleared on every state entry.
- **IDLE.**
  - run=1 -> FETCH next cycle.
  - run=0 -> remain in IDLE.
- **FETCH.**
  - `fetch_en`=1 for every cycle in the state.
  - Stays IMEM_LATENCY cycles, then -> DECODE.
- **DECODE.**
  - `inst_enable`=1 only in the first cycle.
  - Stays DECODE_CYCLES cycles, then -> EXEC.
- **EXEC.**
  - `exec_en`=1 for exactly 1 cycle.
  - Decode flags are sampled this cycle, with priority:
    - MemRead|MemWrite -> MEM
    - else UARTtoReg -> UART (read)
    - else RegtoUART -> UART (write)
    - else -> WB
  - The selected UART direction is latched in a 1-bit register.
  - Multiple flags set: the higher-priority flag wins; the others are ignored.
- **MEM.** `mem_en`=1 for exactly MEM_LATENCY cycles, then -> WB.
- **UART.**
  - Read direction: `uart_rd_req`=1, held until `uart_rx_valid`=1 is sampled.
  - Write direction: `uart_wr_req`=1, held until `uart_tx_ready`=1 is sampled.
  - The completion cycle moves to WB, and the request drops the same edge.
  - There is no timeout; wait is unbounded.
- **WB.**
  - One cycle with `pc_we`=1 and `retire`=1.
  - `reg_we` = RegWrite (sampled in EXEC, registered).
  - Then run=1 -> FETCH, run=0 -> IDLE.
- **Instruction latency.** Base latency with no memory or UART = IMEM_LATENCY + DECODE_CYCLES + 2 cycles. Default = 6.
- **run deasserted mid-instruction.** The current instruction completes through WB; the FSM then idles. It never aborts.
- **Reset mid-instruction.** Immediate return to IDLE; no `retire` and no `pc_we`.
- **Counter wrap.** `cnt` is 4 bits; parameters above 15 are illegal and are rejected by an elaboration-time check.

Optional Feature:
- Macro: PIPELINE_SEQUENCER_PERF_EN.
- Defined:
  - Adds outputs `cycle_count[31:0]` and `retire_count[31:0]`.
  - `cycle_count` increments every cycle while `busy`=1.
  - `retire_count` increments on each `retire`.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: the ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package `core_pkg` holds:
  - the `seq_state_t` enum (IDLE=0, FETCH, DECODE, EXEC, MEM, UART, WB; 3-bit);
  - the `SEQ_CNT_W`=4 constant.
- One natural sub-module: `perf_counters`, containing the two 32-bit counters. It is instantiated only under PIPELINE_SEQUENCER_PERF_EN.

Test Plan:
- **Reset and ALU timing.** Reset low mid-FETCH, then high with run=1 and all flags 0 (RegWrite=1), default parameters.
  - Required: `fetch_en` cycle 1, `inst_enable` cycle 2, `exec_en` cycle 5, `reg_we`/`pc_we`/`retire` cycle 6, `fetch_en` again cycle 7.
- **Load.** MemRead=1, RegWrite=1.
  - Required: `mem_en` high exactly 2 cycles after `exec_en`, then WB; `retire` spacing is 8 cycles.
- **UART read.** UARTtoReg=1, `uart_rx_valid` asserted 10 cycles after EXEC.
  - Required: `uart_rd_req` high 10 cycles, WB on the following cycle, `uart_rd_req` low in WB.
- **UART write, both flags.** RegtoUART=1, MemWrite=1.
  - Required: the MEM path is taken and `uart_wr_req` never asserts.
- **run/reset mid-instruction.**
  - run dropped during DECODE: one `retire`, then IDLE with `busy`=0.
  - reset pulsed during UART: all outputs 0 immediately and no `retire`.
- **Performance counters.** With PIPELINE_SEQUENCER_PERF_EN, run 3 ALU instructions then run=0.
  - Required: `retire_count`=3 and `cycle_count`=18.
